// File: rtl/uart_rx_if.sv
// Serial line and receive-side outputs of the UART receiver.
// The slave modport is the receiver; the master modport drives the line and observes results.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_serial_in;
    logic [DATA_WIDTH-1:0] rx_byte_out;
    logic                  rx_done;
    logic                  rx_active;
    logic                  rx_frame_error;

    modport master (
        output rx_serial_in,
        input  rx_byte_out,
        input  rx_done,
        input  rx_active,
        input  rx_frame_error
    );

    modport slave (
        input  rx_serial_in,
        output rx_byte_out,
        output rx_done,
        output rx_active,
        output rx_frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM, registered outputs.
// A stop bit sampled low reports a frame error and waits for the line to return high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   rx_if
);
    typedef enum logic [2:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } state_t;

    localparam logic [31:0] LP_LAST     = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] LP_HALF     = 32'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]  LP_LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                r_state, w_next_state;
    logic                  r_sync1, r_sync2;
    logic                  w_rx;
    logic [31:0]           r_clk_count, w_clk_count;
    logic [3:0]            r_bit_index, w_bit_index;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic [DATA_WIDTH-1:0] r_byte, w_byte;
    logic                  r_done, w_done;
    logic                  r_active, w_active;
    logic                  r_ferr, w_ferr;
    logic                  w_bit_tick;
    logic                  w_mid_tick;

    assign w_rx       = r_sync2;
    assign w_bit_tick = (r_clk_count == LP_LAST);
    assign w_mid_tick = (r_clk_count == LP_HALF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_clk_count <= '0;
            r_bit_index <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_done      <= 1'b0;
            r_active    <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1     <= rx_if.rx_serial_in;
            r_sync2     <= r_sync1;
            r_state     <= w_next_state;
            r_clk_count <= w_clk_count;
            r_bit_index <= w_bit_index;
            r_shift     <= w_shift;
            r_byte      <= w_byte;
            r_done      <= w_done;
            r_active    <= w_active;
            r_ferr      <= w_ferr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:         if (!w_rx) w_next_state = RX_START;
            RX_START:     if (w_mid_tick) w_next_state = w_rx ? IDLE : RX_DATA;
            RX_DATA:      if (w_bit_tick && (r_bit_index == LP_LAST_BIT)) w_next_state = RX_STOP;
            RX_STOP:      if (w_bit_tick) w_next_state = w_rx ? IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_rx) w_next_state = IDLE;
            default:      w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_clk_count = r_clk_count;
        w_bit_index = r_bit_index;
        w_shift     = r_shift;
        w_byte      = r_byte;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        w_active    = (r_state == RX_START) || (r_state == RX_DATA) || (r_state == RX_STOP);
        unique case (r_state)
            IDLE: begin
                w_clk_count = '0;
                w_bit_index = '0;
            end
            RX_START: begin
                w_clk_count = w_mid_tick ? '0 : r_clk_count + 32'd1;
            end
            RX_DATA: begin
                if (w_bit_tick) begin
                    w_clk_count = '0;
                    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                        if (r_bit_index == 4'(i)) w_shift[i] = w_rx;
                    end
                    w_bit_index = (r_bit_index == LP_LAST_BIT) ? '0 : r_bit_index + 4'd1;
                end else begin
                    w_clk_count = r_clk_count + 32'd1;
                end
            end
            RX_STOP: begin
                if (w_bit_tick) begin
                    w_clk_count = '0;
                    if (w_rx) begin
                        w_byte = r_shift;
                        w_done = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end else begin
                    w_clk_count = r_clk_count + 32'd1;
                end
            end
            RX_WAIT_HIGH: begin
                w_clk_count = '0;
            end
            default: begin
                w_clk_count = '0;
                w_bit_index = '0;
            end
        endcase
    end

    assign rx_if.rx_byte_out    = r_byte;
    assign rx_if.rx_done        = r_done;
    assign rx_if.rx_active      = r_active;
    assign rx_if.rx_frame_error = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written corner sequences.
module tb_uart_rx;
    localparam int CPB = 434;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_byte;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;

    int n_done = 0, n_ferr = 0, n_overlap = 0, n_long = 0;
    logic prev_done = 1'b0, prev_ferr = 1'b0;
    logic [7:0] rx_log[$];

    int t_rise, t_done, t_fall;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_done) begin
                n_done++;
                rx_log.push_back(bus.rx_byte_out);
            end
            if (bus.rx_frame_error) n_ferr++;
            if (bus.rx_done && bus.rx_frame_error) n_overlap++;
            if ((bus.rx_done && prev_done) || (bus.rx_frame_error && prev_ferr)) n_long++;
        end
        prev_done = bus.rx_done;
        prev_ferr = bus.rx_frame_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int cycles);
        bus.rx_serial_in = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one frame starting at a negedge; records output timing relative to the start-bit edge.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        logic [9:0] bits;
        bits   = {stop, data, 1'b0};
        t_rise = -1;
        t_done = -1;
        t_fall = -1;
        for (int n = 0; n < 10 * CPB; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (bus.rx_active && t_rise < 0) t_rise = n;
                if (!bus.rx_active && t_rise >= 0 && t_fall < 0) t_fall = n;
                if (bus.rx_done && t_done < 0) t_done = n;
            end
            bus.rx_serial_in = bits[4'(n / CPB)];
        end
    endtask

    initial begin
        int d0, f0, q0;
        logic [7:0] held;
        logic saw_active, saw_change;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h55, 1'b1, 8'h55, 1, 0};
        vecs[2] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[4] = '{8'hC3, 1'b1, 8'hC3, 1, 0};
        vecs[5] = '{8'h3C, 1'b0, 8'hC3, 0, 1};
        vecs[6] = '{8'h7E, 1'b1, 8'h7E, 1, 0};

        bus.rx_serial_in = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_byte", 32'(bus.rx_byte_out), 32'h00);
        check("reset_done", 32'(bus.rx_done), 32'h0);
        check("reset_active", 32'(bus.rx_active), 32'h0);
        check("reset_ferr", 32'(bus.rx_frame_error), 32'h0);
        reset = 1'b0;
        idle(10);

        for (int i = 0; i < 7; i++) begin
            d0 = n_done;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(20);
            check($sformatf("vec%0d_done", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_byte", i), 32'(bus.rx_byte_out), 32'(vecs[i].exp_byte));
        end

        // rx_active rises 1 cycle after RX_START entry, done follows the stop sample, then active falls
        send_frame(8'h96, 1'b1);
        idle(20);
        check("timing_active_rise", 32'(t_rise), 32'd4);
        check("timing_done", 32'(t_done), 32'd4126);
        check("timing_active_fall", 32'(t_fall), 32'd4127);

        q0 = rx_log.size();
        d0 = n_done;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_done", 32'(n_done - d0), 32'd2);
        check("b2b_first", 32'(rx_log[q0]), 32'h00);
        check("b2b_second", 32'(rx_log[q0 + 1]), 32'hFF);

        d0 = n_done;
        t_rise = -1;
        t_fall = -1;
        for (int n = 0; n < 1000 && t_fall < 0; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (bus.rx_active && t_rise < 0) t_rise = n;
                if (!bus.rx_active && t_rise >= 0 && t_fall < 0) t_fall = n;
            end
            bus.rx_serial_in = (n < 100) ? 1'b0 : 1'b1;
        end
        idle(20);
        check("glitch_active_rise", 32'(t_rise), 32'd4);
        check("glitch_active_fall", 32'(t_fall), 32'd221);
        check("glitch_no_done", 32'(n_done - d0), 32'd0);

        held = bus.rx_byte_out;
        d0 = n_done;
        f0 = n_ferr;
        saw_active = 1'b0;
        saw_change = 1'b0;
        send_frame(8'h3C, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            bus.rx_serial_in = 1'b0;
            if (n > 2 && bus.rx_active) saw_active = 1'b1;
            if (bus.rx_byte_out !== held) saw_change = 1'b1;
        end
        check("break_ferr", 32'(n_ferr - f0), 32'd1);
        check("break_no_done", 32'(n_done - d0), 32'd0);
        check("break_byte_held", 32'(saw_change), 32'd0);
        check("break_no_new_frame", 32'(saw_active), 32'd0);
        idle(20);
        d0 = n_done;
        send_frame(8'h81, 1'b1);
        idle(20);
        check("after_break_done", 32'(n_done - d0), 32'd1);
        check("after_break_byte", 32'(bus.rx_byte_out), 32'h81);

        d0 = n_done;
        f0 = n_ferr;
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h5A, 1'b0};
            for (int n = 0; n < 4 * CPB + CPB / 2; n++) begin
                @(negedge clk);
                bus.rx_serial_in = bits[4'(n / CPB)];
            end
        end
        check("midframe_active", 32'(bus.rx_active), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.rx_serial_in = 1'b1;
        check("rst_mid_byte", 32'(bus.rx_byte_out), 32'h00);
        check("rst_mid_done", 32'(bus.rx_done), 32'h0);
        check("rst_mid_active", 32'(bus.rx_active), 32'h0);
        check("rst_mid_ferr", 32'(bus.rx_frame_error), 32'h0);
        idle(1000);
        check("rst_mid_no_done", 32'(n_done - d0), 32'd0);
        check("rst_mid_no_ferr", 32'(n_ferr - f0), 32'd0);
        d0 = n_done;
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("after_rst_done", 32'(n_done - d0), 32'd1);
        check("after_rst_byte", 32'(bus.rx_byte_out), 32'h5A);

        check("pulse_overlap", 32'(n_overlap), 32'd0);
        check("pulse_too_long", 32'(n_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (minimum 4).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-003 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, meaning the system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port rx_serial_in, input, 1, meaning the asynchronous UART line, idle high.
REQ-007 SHALL have port rx_byte_out, output, DATA_WIDTH, meaning the last correctly framed byte, LSB received first.
REQ-008 SHALL have port rx_done, output, 1, meaning a one-cycle pulse when rx_byte_out is updated.
REQ-009 SHALL have port rx_active, output, 1, meaning a frame is in progress.
REQ-010 SHALL have port rx_frame_error, output, 1, meaning a one-cycle pulse when the stop bit is sampled low.

Function
REQ-011 SHALL pass rx_serial_in through a 2-flop synchronizer (rx_sync), and all decisions SHALL use rx_sync only.
REQ-012 SHALL use the FSM states IDLE, RX_START, RX_DATA, RX_STOP and RX_WAIT_HIGH, with an internal clk_count (32-bit) and bit_index (4-bit).
REQ-013 IDLE: clk_count=0 and bit_index=0; when rx_sync==0, go to RX_START.
REQ-014 RX_START: increment clk_count each cycle; at clk_count==(CLKS_PER_BIT-1)/2 (216 by default), sample rx_sync.
REQ-015 In RX_START, a sample of 0 SHALL clear clk_count and go to RX_DATA; a sample of 1 is a glitch and SHALL go to IDLE with no output pulse.
REQ-016 RX_DATA: count 0..CLKS_PER_BIT-1; at clk_count==CLKS_PER_BIT-1, shift rx_sync into shift register bit bit_index, clear clk_count, and increment bit_index.
REQ-017 After bit_index DATA_WIDTH-1 is sampled, the FSM SHALL clear bit_index and go to RX_STOP.
REQ-018 RX_STOP: count 0..CLKS_PER_BIT-1; at clk_count==CLKS_PER_BIT-1, sample rx_sync.
REQ-019 A stop-bit sample of 1 SHALL load rx_byte_out from the shift register, pulse rx_done for exactly the next cycle, and go to IDLE.
REQ-020 A stop-bit sample of 0 SHALL leave rx_byte_out unchanged, pulse rx_frame_error for exactly the next cycle, and go to RX_WAIT_HIGH.
REQ-021 RX_WAIT_HIGH: remain until rx_sync==1, then go to IDLE; a held-low line (break) SHALL NOT start a new frame.
REQ-022 rx_active SHALL be 1 in RX_START, RX_DATA and RX_STOP, and 0 in IDLE and RX_WAIT_HIGH; it is registered, so it is visible 1 cycle after the state entry.
REQ-023 rx_done and rx_frame_error SHALL never be asserted in the same cycle, and neither SHALL assert for longer than 1 cycle.
REQ-024 After a good stop sample, the next frame's start bit SHALL be accepted, so back-to-back frames are received with no idle gap.
REQ-025 rx_byte_out SHALL hold its value between rx_done pulses.
REQ-026 Sampling is mid-bit: data bit n is sampled (CLKS_PER_BIT-1)/2 + 1 + (n+1)*CLKS_PER_BIT cycles after rx_sync is first seen low in IDLE.

Reset
REQ-027 Reset asserted on any clock edge SHALL force state=IDLE, clk_count=0, bit_index=0 and shift register=0.
REQ-028 Reset SHALL force the outputs rx_byte_out=0, rx_done=0, rx_active=0 and rx_frame_error=0.
REQ-029 Reset SHALL set both synchronizer flops to 1 (idle line).
REQ-030 Reset mid-frame SHALL abort the frame with no rx_done or rx_frame_error pulse; reception SHALL resume at the next falling edge after reset deasserts.

Verification
REQ-031 Bench SHALL cover: a 0xA5 frame at 434 clk/bit -> exactly one rx_done pulse, rx_byte_out=0xA5, rx_frame_error never 1.
REQ-032 Bench SHALL cover: back-to-back frames 0x00 then 0xFF with no gap -> two rx_done pulses, with rx_byte_out=0x00 then 0xFF.
REQ-033 Bench SHALL cover: line low for 100 clocks, then high -> return to IDLE, no rx_done, rx_active falls within 220 cycles.
REQ-034 Bench SHALL cover: frame 0x3C with the stop bit low, held low 2000 clocks, then high, then a valid 0x81 frame -> one rx_frame_error pulse and rx_byte_out unchanged during the low line, followed by rx_done with 0x81.
REQ-035 Bench SHALL cover: reset pulsed during data bit 3 of frame 0x5A -> all outputs 0 the next cycle, no pulse, and a following 0x5A frame received correctly.
REQ-036 Bench SHALL cover: the rx_active timing property -> rises 1 cycle after RX_START entry and stays high until the stop sample.
